// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its consumer: the sampled
// input and prescaler setting going in, measured widths and status coming out.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [7:0]       div;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic             valid;
    logic             timeout;

    modport master (
        output pwm_in, div,
        input  high_count, period_count, valid, timeout
    );

    modport slave (
        input  pwm_in, div,
        output high_count, period_count, valid, timeout
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// prescaled ticks; one tick every div clocks, div=0 disables the block.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic         clock,
    input  logic         reset,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [7:0]             div_q;
    logic [7:0]             pre_q;
    logic [CNT_W-1:0]       per_q;
    logic [CNT_W-1:0]       hi_lat_q;
    logic [CNT_W-1:0]       high_q;
    logic [CNT_W-1:0]       period_q;
    logic                   valid_q;
    logic                   timeout_q;

    logic             sync, rise, fall, tick, sat, abort;
    logic [CNT_W-1:0] per_nxt;

    // Both edges pass through the same flops, so widths are not skewed.
    assign sync  = sync_q[SYNC_STAGES-1];
    assign rise  = sync & ~hist_q;
    assign fall  = ~sync & hist_q;
    assign abort = (div_q == 8'd0) || (bus.div != div_q);

    always_comb begin
        tick    = (pre_q == div_q - 8'd1);
        per_nxt = per_q;
        if (tick && per_q != CNT_MAX)
            per_nxt = per_q + CNT_ONE;
        sat = (per_nxt == CNT_MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            div_q     <= 8'd0;
            pre_q     <= 8'd0;
            per_q     <= '0;
            hi_lat_q  <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            hist_q  <= sync;
            div_q   <= bus.div;
            valid_q <= 1'b0;
            if (abort) begin
                // Disabled or prescaler changed mid-measurement: drop it quietly.
                state    <= IDLE;
                pre_q    <= 8'd0;
                per_q    <= '0;
                hi_lat_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HIGH;
                            pre_q <= 8'd0;
                            per_q <= '0;
                        end
                    end
                    default: begin
                        pre_q <= tick ? 8'd0 : pre_q + 8'd1;
                        per_q <= per_nxt;
                        if (state == LOW && rise) begin
                            // Publish and start the next period on the same edge.
                            high_q    <= hi_lat_q;
                            period_q  <= per_nxt;
                            valid_q   <= 1'b1;
                            timeout_q <= 1'b0;
                            state     <= HIGH;
                            pre_q     <= 8'd0;
                            per_q     <= '0;
                        end else if (sat) begin
                            high_q    <= (state == HIGH) ? CNT_MAX : hi_lat_q;
                            period_q  <= CNT_MAX;
                            valid_q   <= 1'b1;
                            timeout_q <= 1'b1;
                            state     <= IDLE;
                            pre_q     <= 8'd0;
                            per_q     <= '0;
                            hi_lat_q  <= '0;
                        end else if (state == HIGH && fall) begin
                            hi_lat_q <= per_nxt;
                            state    <= LOW;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.high_count   = high_q;
    assign bus.period_count = period_q;
    assign bus.valid        = valid_q;
    assign bus.timeout      = timeout_q;
endmodule
